// File: rtl/conv_engine_param.sv
// conv_engine_param: self-sequenced K x K stride-1 valid convolution over an
// N x N image held in a shared word-addressed memory. A single multiply-
// accumulate is performed per cycle. Results are shifted, saturated to DW
// bits and packed EPW per memory word before being written back.
module conv_engine_param #(
    parameter int DW    = 8,
    parameter int MW    = 32,
    parameter int K     = 4,
    parameter int N     = 16,
    parameter int AW    = 7,
    parameter int SHIFT = 4,
    parameter int ACCW  = 2*DW + $clog2(K*K)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          signed_mode,
    input  logic [AW-1:0] filt_base,
    input  logic [AW-1:0] in_base,
    input  logic [AW-1:0] out_base,
    input  logic [MW-1:0] mem_rdata,
    output logic [AW-1:0] mem_addr,
    output logic          mem_re,
    output logic          mem_we,
    output logic [MW-1:0] mem_wdata,
    output logic          busy,
    output logic          done
);

    localparam int EPW = MW / DW;           // elements per memory word
    localparam int FW  = (K * K) / EPW;     // filter words
    localparam int RW  = N / EPW;           // words per image row
    localparam int M   = N - K + 1;         // output dimension
    localparam int KIW = (K > 1) ? $clog2(K) : 1;
    localparam int NIW = (N > 1) ? $clog2(N) : 1;
    localparam int CW  = $clog2(K*K + N + M*M + 2) + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_F, S_LOAD_ROW, S_CALC, S_FIN, S_WRITE, S_DONE
    } state_t;

    state_t state_q, state_d;

    // Job parameters latched at start
    logic          smode_q;
    logic [AW-1:0] filt_base_q;
    logic [AW-1:0] out_base_q;
    logic [AW-1:0] row_addr_q;     // base address of the next image row to load

    // Load sequencing and read-return tracking
    logic [CW-1:0] rd_cnt_q;
    logic          rd_pend_q;
    logic          rd_filt_q;
    logic [CW-1:0] rd_idx_q;
    logic [CW-1:0] ld_row_q;       // image rows loaded so far in this job

    // Compute position
    logic [KIW-1:0] ti_q, tj_q;
    logic [NIW-1:0] col_q;
    logic [CW-1:0]  row_q;
    logic [CW-1:0]  lane_q;
    logic [CW-1:0]  word_q;
    logic [ACCW-1:0] acc_q;
    logic [MW-1:0]  pack_q;

    logic [DW-1:0] filt_q [K][K];
    logic [DW-1:0] win_q  [K][N];

    // Derived control
    logic ld_f_end, ld_r_end, tap_first, tap_last, col_last, out_last, need_wr, adv;

    assign ld_f_end  = (state_q == S_LOAD_F)   && (rd_cnt_q == CW'(FW));
    assign ld_r_end  = (state_q == S_LOAD_ROW) && (rd_cnt_q == CW'(RW));
    assign tap_first = (ti_q == '0) && (tj_q == '0);
    assign tap_last  = (ti_q == KIW'(K-1)) && (tj_q == KIW'(K-1));
    assign col_last  = (col_q == NIW'(M-1));
    assign out_last  = col_last && (row_q == CW'(M-1));
    assign need_wr   = (lane_q == CW'(EPW-1)) || out_last;
    assign adv       = ((state_q == S_FIN) && !need_wr) || (state_q == S_WRITE);

    // MAC operand selection and extension to accumulator width
    logic [NIW-1:0]  wc;
    logic [DW-1:0]   f_el, x_el;
    logic [ACCW-1:0] f_ext, x_ext, prod;

    assign wc    = col_q + NIW'(tj_q);
    assign f_el  = filt_q[ti_q][tj_q];
    assign x_el  = win_q[ti_q][wc];
    assign f_ext = smode_q ? {{(ACCW-DW){f_el[DW-1]}}, f_el} : {{(ACCW-DW){1'b0}}, f_el};
    assign x_ext = smode_q ? {{(ACCW-DW){x_el[DW-1]}}, x_el} : {{(ACCW-DW){1'b0}}, x_el};
    assign prod  = f_ext * x_ext;

    // Shift kept in separate assigns so the signed shift stays arithmetic
    logic signed [ACCW-1:0] sh_s;
    logic        [ACCW-1:0] sh_u;
    logic        [DW-1:0]   res;

    assign sh_s = $signed(acc_q) >>> SHIFT;
    assign sh_u = acc_q >> SHIFT;

    // Saturate the shifted accumulator to the DW-bit output range
    always_comb begin
        res = '0;
        if (smode_q) begin
            if ((&sh_s[ACCW-1:DW-1]) || !(|sh_s[ACCW-1:DW-1]))
                res = sh_s[DW-1:0];
            else if (sh_s[ACCW-1])
                res = {1'b1, {(DW-1){1'b0}}};
            else
                res = {1'b0, {(DW-1){1'b1}}};
        end else begin
            if (|sh_u[ACCW-1:DW])
                res = '1;
            else
                res = sh_u[DW-1:0];
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (start) state_d = S_LOAD_F;
            S_LOAD_F:   if (ld_f_end) state_d = S_LOAD_ROW;
            S_LOAD_ROW: if (ld_r_end) state_d = (ld_row_q < CW'(K-1)) ? S_LOAD_ROW : S_CALC;
            S_CALC:     if (tap_last) state_d = S_FIN;
            S_FIN: begin
                if (need_wr)       state_d = S_WRITE;
                else if (col_last) state_d = S_LOAD_ROW;
                else               state_d = S_CALC;
            end
            S_WRITE: begin
                if (out_last)      state_d = S_DONE;
                else if (col_last) state_d = S_LOAD_ROW;
                else               state_d = S_CALC;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs; all derive from registered state so reset clears them at once
    always_comb begin
        mem_re    = ((state_q == S_LOAD_F)   && (rd_cnt_q < CW'(FW))) ||
                    ((state_q == S_LOAD_ROW) && (rd_cnt_q < CW'(RW)));
        mem_we    = (state_q == S_WRITE);
        mem_wdata = (state_q == S_WRITE) ? pack_q : '0;
        mem_addr  = '0;
        if (state_q == S_LOAD_F && mem_re)
            mem_addr = filt_base_q + AW'(rd_cnt_q);
        else if (state_q == S_LOAD_ROW && mem_re)
            mem_addr = row_addr_q + AW'(rd_cnt_q);
        else if (state_q == S_WRITE)
            mem_addr = out_base_q + AW'(word_q);
        busy = (state_q != S_IDLE);
        done = (state_q == S_DONE);
    end

    // Remember which element slot the in-flight read will fill
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_pend_q <= 1'b0;
            rd_filt_q <= 1'b0;
            rd_idx_q  <= '0;
        end else begin
            rd_pend_q <= mem_re;
            rd_filt_q <= (state_q == S_LOAD_F);
            rd_idx_q  <= rd_cnt_q;
        end
    end

    // Filter registers, filled from returning filter words
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < K; i++)
                for (int j = 0; j < K; j++)
                    filt_q[i][j] <= '0;
        end else if (rd_pend_q && rd_filt_q) begin
            for (int i = 0; i < K; i++)
                for (int j = 0; j < K; j++)
                    if (rd_idx_q == CW'((i*K + j) / EPW))
                        filt_q[i][j] <= mem_rdata[DW*((i*K + j) % EPW) +: DW];
        end
    end

    // Line buffer: shift up on row-load entry, new row lands in the bottom row
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < K; i++)
                for (int n = 0; n < N; n++)
                    win_q[i][n] <= '0;
        end else begin
            if (state_q == S_LOAD_ROW && rd_cnt_q == '0)
                for (int i = 0; i < K-1; i++)
                    win_q[i] <= win_q[i+1];
            if (rd_pend_q && !rd_filt_q)
                for (int n = 0; n < N; n++)
                    if (rd_idx_q == CW'(n / EPW))
                        win_q[K-1][n] <= mem_rdata[DW*(n % EPW) +: DW];
        end
    end

    // Job sequencing counters, accumulator and output packing
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            smode_q     <= 1'b0;
            filt_base_q <= '0;
            out_base_q  <= '0;
            row_addr_q  <= '0;
            rd_cnt_q    <= '0;
            ld_row_q    <= '0;
            ti_q        <= '0;
            tj_q        <= '0;
            col_q       <= '0;
            row_q       <= '0;
            lane_q      <= '0;
            word_q      <= '0;
            acc_q       <= '0;
            pack_q      <= '0;
        end else begin
            if (state_q == S_IDLE && start) begin
                smode_q     <= signed_mode;
                filt_base_q <= filt_base;
                row_addr_q  <= in_base;
                out_base_q  <= out_base;
                ld_row_q    <= '0;
                ti_q        <= '0;
                tj_q        <= '0;
                col_q       <= '0;
                row_q       <= '0;
                lane_q      <= '0;
                word_q      <= '0;
                acc_q       <= '0;
                pack_q      <= '0;
            end

            if ((state_q == S_LOAD_F && !ld_f_end) || (state_q == S_LOAD_ROW && !ld_r_end))
                rd_cnt_q <= rd_cnt_q + CW'(1);
            else
                rd_cnt_q <= '0;

            if (ld_r_end) begin
                ld_row_q   <= ld_row_q + CW'(1);
                row_addr_q <= row_addr_q + AW'(RW);
            end

            if (state_q == S_CALC) begin
                acc_q <= tap_first ? prod : (acc_q + prod);
                if (tj_q == KIW'(K-1)) begin
                    tj_q <= '0;
                    ti_q <= (ti_q == KIW'(K-1)) ? '0 : (ti_q + KIW'(1));
                end else begin
                    tj_q <= tj_q + KIW'(1);
                end
            end

            if (state_q == S_FIN)
                for (int p = 0; p < EPW; p++)
                    if (lane_q == CW'(p))
                        pack_q[DW*p +: DW] <= res;

            if (state_q == S_WRITE) begin
                pack_q <= '0;
                word_q <= word_q + CW'(1);
            end

            if (adv) begin
                lane_q <= (lane_q == CW'(EPW-1)) ? '0 : (lane_q + CW'(1));
                if (col_last) begin
                    col_q <= '0;
                    row_q <= row_q + CW'(1);
                end else begin
                    col_q <= col_q + NIW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_conv_engine_param.sv
// Bench for conv_engine_param: a default (K=4) and a K=8 instance share one
// memory model through a select. Jobs come from a table of directed vectors
// with hand-computed expectations; every written word is also compared with a
// straightforward reference convolution.
`timescale 1ns/1ps
module tb_conv_engine_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, smode, sel;
    logic [6:0]  fbase, ibase, obase;
    logic [31:0] rdata;

    logic [6:0]  a4, a8;
    logic        re4, re8, we4, we8, busy4, busy8, done4, done8;
    logic [31:0] wd4, wd8;
    logic        start4, start8;

    assign start4 = start & ~sel;
    assign start8 = start & sel;

    conv_engine_param #(.K(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4), .signed_mode(smode),
        .filt_base(fbase), .in_base(ibase), .out_base(obase), .mem_rdata(rdata),
        .mem_addr(a4), .mem_re(re4), .mem_we(we4), .mem_wdata(wd4),
        .busy(busy4), .done(done4)
    );

    conv_engine_param #(.K(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .signed_mode(smode),
        .filt_base(fbase), .in_base(ibase), .out_base(obase), .mem_rdata(rdata),
        .mem_addr(a8), .mem_re(re8), .mem_we(we8), .mem_wdata(wd8),
        .busy(busy8), .done(done8)
    );

    logic [6:0]  b_addr;
    logic        b_re, b_we, b_busy, b_done;
    logic [31:0] b_wdata;
    assign b_addr  = sel ? a8    : a4;
    assign b_re    = sel ? re8   : re4;
    assign b_we    = sel ? we8   : we4;
    assign b_wdata = sel ? wd8   : wd4;
    assign b_busy  = sel ? busy8 : busy4;
    assign b_done  = sel ? done8 : done4;

    logic [31:0] mem [128];
    always @(posedge clk) if (b_re) rdata <= mem[b_addr];

    logic [7:0]  fb [8][8];
    logic [7:0]  ib [16][16];
    logic [6:0]  wa [64];
    logic [31:0] wdat [64];

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        bit        sel;
        bit        smode;
        int        fpat;       // 0 identity, 1 all FF, 2 all 80, 3 ramp-8
        int        ipat;       // 0 ramp, 1 FF, 2 80, 3 7F, 4 mixed
        bit [6:0]  obase;
        bit        extra;      // pulse start while busy
        bit        hand;       // hand-computed first/last words valid
        int        exp_cycles;
        int        exp_words;
        bit [6:0]  first_addr;
        bit [31:0] first_data;
        bit [6:0]  last_addr;
        bit [31:0] last_data;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic load_mem(input int kk, input int fpat, input int ipat);
        int e;
        for (int a = 0; a < 128; a++) mem[a] = 32'h0;
        for (int i = 0; i < 8; i++) for (int j = 0; j < 8; j++) fb[i][j] = 8'h00;
        for (int i = 0; i < kk; i++) begin
            for (int j = 0; j < kk; j++) begin
                case (fpat)
                    0:       fb[i][j] = (i == 0 && j == 0) ? 8'd16 : 8'd0;
                    1:       fb[i][j] = 8'hFF;
                    2:       fb[i][j] = 8'h80;
                    default: fb[i][j] = 8'(i*kk + j - 8);
                endcase
                e = i*kk + j;
                mem[112 + e/4][8*(e%4) +: 8] = fb[i][j];
            end
        end
        for (int r = 0; r < 16; r++) begin
            for (int c = 0; c < 16; c++) begin
                case (ipat)
                    0:       ib[r][c] = 8'((16*r + c) % 256);
                    1:       ib[r][c] = 8'hFF;
                    2:       ib[r][c] = 8'h80;
                    3:       ib[r][c] = 8'h7F;
                    default: ib[r][c] = 8'(7*r + 3*c + 5);
                endcase
                mem[r*4 + c/4][8*(c%4) +: 8] = ib[r][c];
            end
        end
    endtask

    function automatic logic [7:0] ref_px(input int kk, input bit sm, input int r, input int c);
        int acc, f, x;
        acc = 0;
        for (int i = 0; i < kk; i++) begin
            for (int j = 0; j < kk; j++) begin
                f = sm ? int'($signed(fb[i][j]))       : int'(fb[i][j]);
                x = sm ? int'($signed(ib[r+i][c+j]))   : int'(ib[r+i][c+j]);
                acc += f * x;
            end
        end
        acc = acc >>> 4;
        if (sm) begin
            if (acc > 127)       return 8'h7F;
            else if (acc < -128) return 8'h80;
            else                 return acc[7:0];
        end else begin
            if (acc > 255) return 8'hFF;
            else           return acc[7:0];
        end
    endfunction

    task automatic run_vec(input int v);
        vec_t t;
        int kk, m, nout, nexp, cyc, dn, done_at, nwr, guard;
        bit to;
        logic [31:0] exp_w [64];
        t  = vecs[v];
        kk = t.sel ? 8 : 4;
        m  = 16 - kk + 1;
        nout = m * m;
        nexp = (nout + 3) / 4;
        sel = t.sel;
        load_mem(kk, t.fpat, t.ipat);
        for (int w = 0; w < 64; w++) exp_w[w] = 32'h0;
        for (int idx = 0; idx < nout; idx++)
            exp_w[idx/4][8*(idx%4) +: 8] = ref_px(kk, t.smode, idx / m, idx % m);

        @(negedge clk);
        smode = t.smode; fbase = 7'h70; ibase = 7'h00; obase = t.obase; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0; dn = 0; done_at = -1; nwr = 0; guard = 0; to = 1'b1;
        while (guard < 20000) begin
            if (!b_busy) begin
                to = 1'b0;
                break;
            end
            cyc++;
            if (b_done) begin
                dn++;
                done_at = cyc;
            end
            if (b_we) begin
                if (nwr < 64) begin
                    wa[nwr]   = b_addr;
                    wdat[nwr] = b_wdata;
                end
                nwr++;
            end
            start = t.extra && (cyc % 500 == 100);
            @(negedge clk);
            guard++;
        end
        start = 1'b0;

        $display("job %0d: K=%0d signed=%0d out_base=0x%0h busy_cycles=%0d writes=%0d done_pulses=%0d",
                 v, kk, t.smode, t.obase, cyc, nwr, dn);
        check($sformatf("v%0d timeout", v), 64'(to), 64'd0);
        check($sformatf("v%0d busy_cycles", v), 64'(cyc), 64'(t.exp_cycles));
        check($sformatf("v%0d done_pulses", v), 64'(dn), 64'd1);
        check($sformatf("v%0d done_in_last_busy_cycle", v), 64'(done_at), 64'(cyc));
        check($sformatf("v%0d write_count", v), 64'(nwr), 64'(t.exp_words));
        if (t.hand && nwr > 0 && nwr <= 64) begin
            check($sformatf("v%0d first_word", v), {25'd0, wa[0], wdat[0]},
                  {25'd0, t.first_addr, t.first_data});
            check($sformatf("v%0d last_word", v), {25'd0, wa[nwr-1], wdat[nwr-1]},
                  {25'd0, t.last_addr, t.last_data});
        end
        for (int w = 0; w < nexp && w < nwr && w < 64; w++)
            check($sformatf("v%0d word%0d", v, w), {25'd0, wa[w], wdat[w]},
                  {25'd0, 7'(t.obase + 7'(w)), exp_w[w]});
        repeat (2) @(negedge clk);
        check($sformatf("v%0d idle_after_done", v), 64'(b_busy), 64'd0);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard, nw;
        vecs[0] = '{sel:0, smode:0, fpat:0, ipat:0, obase:7'h40, extra:1, hand:1, exp_cycles:3002,
                    exp_words:43, first_addr:7'h40, first_data:32'h03020100,
                    last_addr:7'h6A, last_data:32'h000000CC};
        vecs[1] = '{sel:0, smode:0, fpat:1, ipat:1, obase:7'h40, extra:0, hand:1, exp_cycles:3002,
                    exp_words:43, first_addr:7'h40, first_data:32'hFFFFFFFF,
                    last_addr:7'h6A, last_data:32'h000000FF};
        vecs[2] = '{sel:0, smode:1, fpat:2, ipat:2, obase:7'h40, extra:0, hand:1, exp_cycles:3002,
                    exp_words:43, first_addr:7'h40, first_data:32'h7F7F7F7F,
                    last_addr:7'h6A, last_data:32'h0000007F};
        vecs[3] = '{sel:0, smode:1, fpat:1, ipat:3, obase:7'h40, extra:0, hand:1, exp_cycles:3002,
                    exp_words:43, first_addr:7'h40, first_data:32'h81818181,
                    last_addr:7'h6A, last_data:32'h00000081};
        vecs[4] = '{sel:0, smode:0, fpat:0, ipat:0, obase:7'h7F, extra:0, hand:1, exp_cycles:3002,
                    exp_words:43, first_addr:7'h7F, first_data:32'h03020100,
                    last_addr:7'h29, last_data:32'h000000CC};
        vecs[5] = '{sel:0, smode:1, fpat:3, ipat:4, obase:7'h40, extra:0, hand:0, exp_cycles:3002,
                    exp_words:43, first_addr:7'h0, first_data:32'h0,
                    last_addr:7'h0, last_data:32'h0};
        vecs[6] = '{sel:0, smode:0, fpat:3, ipat:4, obase:7'h44, extra:0, hand:0, exp_cycles:3002,
                    exp_words:43, first_addr:7'h0, first_data:32'h0,
                    last_addr:7'h0, last_data:32'h0};
        vecs[7] = '{sel:1, smode:0, fpat:0, ipat:0, obase:7'h50, extra:0, hand:1, exp_cycles:5384,
                    exp_words:21, first_addr:7'h50, first_data:32'h03020100,
                    last_addr:7'h64, last_data:32'h00000088};

        // Reset: outputs held at zero while start toggles under reset
        rst = 1'b0; start = 1'b0; sel = 1'b0; smode = 1'b0;
        fbase = 7'h00; ibase = 7'h00; obase = 7'h00;
        repeat (2) @(negedge clk);
        start = 1'b1;
        repeat (3) @(negedge clk);
        check("rst busy",  64'(busy4), 64'd0);
        check("rst done",  64'(done4), 64'd0);
        check("rst re",    64'(re4),   64'd0);
        check("rst we",    64'(we4),   64'd0);
        check("rst addr",  64'(a4),    64'd0);
        check("rst wdata", 64'(wd4),   64'd0);
        check("rst busy8", 64'(busy8), 64'd0);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        check("post-rst busy",  64'(busy4), 64'd0);
        check("post-rst busy8", 64'(busy8), 64'd0);

        for (int v = 0; v < 7; v++) run_vec(v);

        // Reset in the middle of output row 5, then rerun the identity job
        sel = 1'b0;
        load_mem(4, 0, 0);
        @(negedge clk);
        smode = 1'b0; fbase = 7'h70; ibase = 7'h00; obase = 7'h40; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        nw = 0; guard = 0;
        while (nw < 17 && guard < 5000) begin
            if (we4) nw++;
            @(negedge clk);
            guard++;
        end
        check("midrst reached row5", 64'(nw), 64'd17);
        repeat (5) @(negedge clk);
        check("midrst busy before", 64'(busy4), 64'd1);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("midrst busy", 64'(busy4), 64'd0);
        check("midrst we",   64'(we4),   64'd0);
        check("midrst re",   64'(re4),   64'd0);
        check("midrst done", 64'(done4), 64'd0);
        nw = 0;
        repeat (3) begin
            @(negedge clk);
            if (we4) nw++;
        end
        check("midrst no write in reset", 64'(nw), 64'd0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("midrst idle after release", 64'(busy4), 64'd0);
        $display("reset abort: job abandoned during row 5");
        run_vec(0);

        run_vec(7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
